// File: rtl/seq_multdiv_pkg.sv
// -----------------------------------------------------------------------------
// seq_multdiv_pkg
// Shared definitions for the sequential multiply/divide unit:
//   MD_WIDTH      default operand/result width
//   md_state_t    FSM state encoding (2-bit): ST_IDLE, ST_MUL, ST_DIV, ST_FIX
//   md_op_t       per-operation bookkeeping captured on the start edge
//   md_cnt_width  step-counter width derived from an operand width
// -----------------------------------------------------------------------------
package seq_multdiv_pkg;

   localparam int MD_WIDTH = 32;

   // FSM states. IDLE waits for a start, MUL/DIV run one step per clock,
   // FIX applies the result sign and raises the ready strobe.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_t;

   // What the FIX state needs to know about the operation in flight.
   typedef struct packed {
      logic is_mul;
      logic div_zero;
      logic sign_a;
      logic sign_b;
   } md_op_t;

   // One extra bit so the counter can hold WIDTH itself without wrapping.
   function automatic int md_cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/seq_multdiv_if.sv
// -----------------------------------------------------------------------------
// seq_multdiv_if
// Operand/control/result bundle between the execute stage and seq_multdiv.
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   ctrl_MULT       one-cycle start pulse, multiply (wins over ctrl_DIV)
//   ctrl_DIV        one-cycle start pulse, divide
//   data_result     product low half or quotient, held until the next result
//   data_exception  overflow / divide-by-zero, valid with data_resultRDY
//   data_resultRDY  one-cycle strobe: result and exception just updated
//   busy            operation in progress
// Modports: master drives operands and start pulses, slave is the unit.
// -----------------------------------------------------------------------------
interface seq_multdiv_if
   import seq_multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) ();

   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output data_operandA,
      output data_operandB,
      output ctrl_MULT,
      output ctrl_DIV,
      input  data_result,
      input  data_exception,
      input  data_resultRDY,
      input  busy
   );

   modport slave (
      input  data_operandA,
      input  data_operandB,
      input  ctrl_MULT,
      input  ctrl_DIV,
      output data_result,
      output data_exception,
      output data_resultRDY,
      output busy
   );

endinterface

// File: rtl/md_step_counter.sv
// -----------------------------------------------------------------------------
// md_step_counter
// Counts the shift-add / restoring steps of one operation.
//   clock    rising-edge clock
//   reset    asynchronous, active-high
//   clear    synchronous clear, asserted on the start edge
//   enable   advance one step
//   done     high while the count equals WIDTH-1, i.e. the last step is
//            being performed on the coming edge
// -----------------------------------------------------------------------------
module md_step_counter
   import seq_multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = md_cnt_width(WIDTH)
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);

   logic [CNT_W-1:0] count;

   // The step count restarts on every start so that an aborted operation
   // leaves nothing behind; clear has priority over counting.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign done = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_multdiv.sv
// -----------------------------------------------------------------------------
// seq_multdiv
// Sequential signed multiply/divide unit sitting beside the execute-stage ALU.
// Multiply is radix-2 shift-add (one partial product per clock), divide is
// restoring division (one quotient bit per clock). Both work on magnitudes and
// fix the sign in a final FIX cycle, which also detects overflow.
//   clock   rising-edge clock
//   reset   asynchronous, active-high; clears every output and aborts any op
//   bus     seq_multdiv_if slave modport (operands, start pulses, results)
// A result appears WIDTH+1 edges after the start edge; a divide by zero
// reports after a single edge.
// -----------------------------------------------------------------------------
module seq_multdiv
   import seq_multdiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic         clock,
   input  logic         reset,
   seq_multdiv_if.slave bus
);

   localparam int CNT_W = md_cnt_width(WIDTH);

   md_state_t          state;
   md_state_t          next_state;
   md_op_t             op;

   logic               start;
   logic               start_mul;
   logic               b_zero;
   logic               step_done;
   logic               neg;

   logic [WIDTH:0]     ext_a;
   logic [WIDTH:0]     ext_b;
   logic [WIDTH:0]     abs_a;
   logic [WIDTH:0]     abs_b;

   logic [WIDTH:0]     mag_a;
   logic [WIDTH:0]     mag_b;
   logic [WIDTH:0]     acc_hi;
   logic [WIDTH-1:0]   acc_lo;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;

   logic [2*WIDTH-1:0] prod_mag;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH:0]     prod_top;
   logic [WIDTH-1:0]   quo_signed;
   logic [WIDTH-1:0]   fix_result;
   logic               fix_exception;

   logic [WIDTH-1:0]   result_q;
   logic               exception_q;
   logic               rdy_q;
   logic               busy_q;

   assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
   assign start_mul = bus.ctrl_MULT;
   assign b_zero    = (bus.data_operandB == '0);

   // Operand magnitudes are one bit wider than the operands so that the
   // magnitude of the most negative value is representable.
   assign ext_a = {bus.data_operandA[WIDTH-1], bus.data_operandA};
   assign ext_b = {bus.data_operandB[WIDTH-1], bus.data_operandB};
   assign abs_a = ext_a[WIDTH] ? -ext_a : ext_a;
   assign abs_b = ext_b[WIDTH] ? -ext_b : ext_b;

   md_step_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_step_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (start),
      .enable ((state == ST_MUL) || (state == ST_DIV)),
      .done   (step_done)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A start is honoured in every state: it aborts any
   // operation in flight, and when it coincides with FIX the old result is
   // still written while the new operation begins. A divide by zero has
   // nothing to iterate over, so it goes straight to FIX.
   always_comb begin
      next_state = state;
      if (start) begin
         if (start_mul) begin
            next_state = ST_MUL;
         end else if (b_zero) begin
            next_state = ST_FIX;
         end else begin
            next_state = ST_DIV;
         end
      end else begin
         case (state)
            ST_MUL, ST_DIV: begin
               if (step_done) begin
                  next_state = ST_FIX;
               end
            end
            ST_FIX: begin
               next_state = ST_IDLE;
            end
            default: begin
               next_state = state;
            end
         endcase
      end
   end

   // One multiply step: add the multiplicand when the current multiplier bit
   // is set, then shift the {acc_hi, acc_lo} pair right by one. The low half
   // starts out holding the multiplier and fills with product bits.
   assign mul_sum = acc_hi + (acc_lo[0] ? mag_a : '0);

   // One restoring-divide step: shift the next dividend bit into the partial
   // remainder and try subtracting the divisor. acc_lo starts as the dividend
   // and fills with quotient bits from the right.
   assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
   assign div_diff  = {1'b0, div_shift} - {1'b0, mag_b};

   // Datapath registers: load magnitudes and sign bits on a start, otherwise
   // advance one step per clock while MUL or DIV is active.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op     <= '0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
      end else if (start) begin
         op.is_mul   <= start_mul;
         op.div_zero <= ~start_mul & b_zero;
         op.sign_a   <= bus.data_operandA[WIDTH-1];
         op.sign_b   <= bus.data_operandB[WIDTH-1];
         mag_a       <= abs_a;
         mag_b       <= abs_b;
         acc_hi      <= '0;
         acc_lo      <= start_mul ? abs_b[WIDTH-1:0] : abs_a[WIDTH-1:0];
      end else if (state == ST_MUL) begin
         acc_hi <= {1'b0, mul_sum[WIDTH:1]};
         acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else if (state == ST_DIV) begin
         acc_hi <= div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
         acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH+1]};
      end
   end

   // Sign fix. The product magnitude never exceeds 2^(2*WIDTH-2), so the low
   // 2*WIDTH bits of the accumulator pair hold it exactly. The product fits
   // the result only if its top WIDTH+1 bits are a pure sign extension. The
   // only quotient that can overflow is a positive one with its MSB set,
   // which happens solely for MIN / -1; the raw bits then read back as MIN.
   assign neg         = op.sign_a ^ op.sign_b;
   assign prod_mag    = {acc_hi[WIDTH-1:0], acc_lo};
   assign prod_signed = neg ? -prod_mag : prod_mag;
   assign prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
   assign quo_signed  = neg ? -acc_lo : acc_lo;

   always_comb begin
      fix_result    = '0;
      fix_exception = 1'b0;
      if (op.div_zero) begin
         fix_result    = '0;
         fix_exception = 1'b1;
      end else if (op.is_mul) begin
         fix_result    = prod_signed[WIDTH-1:0];
         fix_exception = (|prod_top) & ~(&prod_top);
      end else begin
         fix_result    = quo_signed;
         fix_exception = ~neg & acc_lo[WIDTH-1];
      end
   end

   // Output registers. The result and exception only change when FIX
   // completes and otherwise hold. busy rises one edge after the start and
   // covers the step cycles and the FIX cycle, dropping as the ready strobe
   // rises; a divide by zero is over before busy would ever rise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         result_q    <= '0;
         exception_q <= 1'b0;
         rdy_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         rdy_q  <= (state == ST_FIX);
         busy_q <= ((state == ST_MUL) || (state == ST_DIV)) &&
                   (next_state != ST_IDLE);
         if (state == ST_FIX) begin
            result_q    <= fix_result;
            exception_q <= fix_exception;
         end
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exception_q;
   assign bus.data_resultRDY = rdy_q;
   assign bus.busy           = busy_q;

endmodule
